// File: rtl/seq_shift_add_mult_if.sv
// Operand/result bundle between a multiply requester and the shift-add multiplier.
// Latency: none (wiring only).
// Backpressure: none; the requester watches busy/done and the unit ignores start while busy.
interface seq_shift_add_mult_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, optional two's complement mode.
// Latency: WIDTH cycles from accepted start to done; with SEQ_MULT_EARLY_TERM_EN defined, it is
// as few as 1 cycle once the remaining multiplier bits are all zero.
// Backpressure: start is only honoured in IDLE; requests seen in RUN or DONE are dropped, not queued.
module seq_shift_add_mult #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_shift_add_mult_if.slave   bus
);
    localparam int              CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    // a_sh shifts right so bit 0 is always the multiplier bit being processed;
    // b_sh shifts left so it always carries the current B<<i weight.
    logic [WIDTH-1:0]       a_sh;
    logic [2*WIDTH-1:0]     b_sh;
    logic [2*WIDTH-1:0]     b_ext;
    logic [2*WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]     acc_nxt;
    logic [2*WIDTH-1:0]     addend;
    logic [2*WIDTH-1:0]     product_q;
    logic [CW-1:0]          cnt;
    logic                   last_bit;

    // Operand extension, per-bit partial product and completion detection.
    always_comb begin
        b_ext  = (SIGNED != 0) ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
        addend = a_sh[0] ? b_sh : '0;
        // The sign bit of a two's complement multiplier carries weight -2^(W-1).
        if ((SIGNED != 0) && (cnt == LAST_CNT)) begin
            acc_nxt = acc - addend;
        end else begin
            acc_nxt = acc + addend;
        end
`ifdef SEQ_MULT_EARLY_TERM_EN
        // Nothing left to add once every higher bit is zero; a negative multiplier
        // keeps its sign bit set so it always runs the full width.
        last_bit = (cnt == LAST_CNT) || (a_sh[WIDTH-1:1] == '0);
`else
        last_bit = (cnt == LAST_CNT);
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -start-> RUN -last bit-> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, accumulate one bit per RUN cycle,
    // and publish the product only on the completing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh <= bus.a;
                        b_sh <= b_ext;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh << 1;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        product_q <= acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult: unsigned and signed instances on one clock.
// Latency: expected completion cycles follow the early-termination build option.
// Backpressure: exercises start while busy and start held high continuously.
module tb_seq_shift_add_mult;
    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    seq_shift_add_mult_if #(.WIDTH(8)) bu ();
    seq_shift_add_mult_if #(.WIDTH(8)) bs ();

    seq_shift_add_mult #(.WIDTH(8), .SIGNED(0)) dut_u (
        .clk   (clk),
        .reset (reset),
        .bus   (bu.slave)
    );

    seq_shift_add_mult #(.WIDTH(8), .SIGNED(1)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bs.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one request for a single edge; returns with that accept edge just passed.
    task automatic issue(input bit sgn, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        if (sgn) begin bs.start = 1'b1; bs.a = av; bs.b = bv; end
        else     begin bu.start = 1'b1; bu.a = av; bu.b = bv; end
        @(posedge clk);
        #1;
        bs.start = 1'b0;
        bu.start = 1'b0;
    endtask

    // Counts edges after accept until done is seen; -1 if the budget runs out.
    task automatic wait_done(input bit sgn, output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (sgn ? bs.done : bu.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input bit sgn, input logic [7:0] av,
                          input logic [7:0] bv, input int exp_lat, input logic [15:0] exp_p);
        int lat;
        issue(sgn, av, bv);
        check({tag, "_busy_e0"}, sgn ? bs.busy : bu.busy, 1);
        wait_done(sgn, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_prod"}, sgn ? bs.product : bu.product, exp_p);
        check({tag, "_busy_done"}, sgn ? bs.busy : bu.busy, 0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, sgn ? bs.done : bu.done, 0);
        check({tag, "_prod_hold"}, sgn ? bs.product : bu.product, exp_p);
    endtask

`ifdef SEQ_MULT_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    initial begin
        int n, lat, t1, t2;
        logic [15:0] p1, p2;

        bu.start = 1'b0; bu.a = '0; bu.b = '0;
        bs.start = 1'b0; bs.a = '0; bs.b = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_busy", bu.busy, 0);
        check("rst_done", bu.done, 0);
        check("rst_prod", bu.product, 0);
        check("rst_prod_s", bs.product, 0);

        // Full-scale unsigned, then signed corner cases.
        run_op("u255x255", 1'b0, 8'd255, 8'd255, 8, 16'hFE01);
        run_op("s_m3x5", 1'b1, 8'hFD, 8'd5, 8, 16'hFFF1);
        run_op("s_m128xm128", 1'b1, 8'h80, 8'h80, 8, 16'h4000);

        // Start while busy must be dropped.
        issue(1'b0, 8'd6, 8'd7);
        n = 0; lat = -1; p1 = '0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin bu.start = 1'b1; bu.a = 8'd1; bu.b = 8'd1; end
            if (k == 3) bu.start = 1'b0;
            if (bu.done) begin
                n++;
                if (n == 1) begin lat = k; p1 = bu.product; end
            end
        end
        check("busy_start_ndone", n, 1);
        check("busy_start_lat", lat, ET ? 3 : 8);
        check("busy_start_prod", p1, 16'd42);

        // Reset mid-op aborts without a done pulse and clears the held product.
        issue(1'b0, 8'd9, 8'd9);
        n = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            if (bu.done) n++;
        end
        reset = 1'b1;
        #1;
        check("midrst_nodone", n, 0);
        check("midrst_busy", bu.busy, 0);
        check("midrst_done", bu.done, 0);
        check("midrst_prod", bu.product, 0);
        @(negedge clk);
        reset = 1'b0;
        run_op("after_rst", 1'b0, 8'd2, 8'd3, ET ? 2 : 8, 16'd6);

        // Early-termination sensitive operands; results identical either way.
        run_op("a1xb200", 1'b0, 8'd1, 8'd200, ET ? 1 : 8, 16'd200);
        run_op("a0xb77", 1'b0, 8'd0, 8'd77, ET ? 1 : 8, 16'd0);
        run_op("a80xb3", 1'b0, 8'h80, 8'd3, 8, 16'd384);
        run_op("s_2x_m7", 1'b1, 8'd2, 8'hF9, ET ? 2 : 8, 16'hFFF2);

        // Back-to-back with start held; operand change after accept only affects the next op.
        @(negedge clk);
        bu.start = 1'b1; bu.a = 8'd3; bu.b = 8'd4;
        @(posedge clk);
        #1;
        bu.a = 8'd5; bu.b = 8'd6;
        n = 0; t1 = -1; t2 = -1; p1 = '0; p2 = '0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (bu.done) begin
                n++;
                if (n == 1) begin t1 = k; p1 = bu.product; end
                if (n == 2) begin t2 = k; p2 = bu.product; bu.start = 1'b0; break; end
            end
        end
        check("b2b_first_lat", t1, ET ? 2 : 8);
        check("b2b_prod1", p1, 16'd12);
        check("b2b_spacing", t2 - t1, ET ? 5 : 10);
        check("b2b_prod2", p2, 16'd30);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_idle", bu.busy, 0);
        check("b2b_hold", bu.product, 16'd30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
